lbg_codebook_bist: RTL and testbench
====================================

# lbg_codebook_bist

Parametrised self-checking built-in test engine for the VQ/LBG codebook SDPRAMs. One instance drives the write and read ports of one codebook RAM, which may be 13- or 14-bit wide and 16 to 1024 entries deep, all on `wr_clk`. Three modes are supported:
- fill with a known pattern, then read back and compare;
- fill with an address pattern, then compare;
- read only the init-file contents and produce a checksum.

It replaces per-IP hand benches and sits beside the codebook RAM in audio bring-up builds.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: RAM address width; depth N = 2^ADDR_WIDTH, legal 4..10.
- `DATA_WIDTH`, default 14: RAM data width, legal 1..64.
- `RD_LATENCY`, default 1: RAM read latency in cycles, 1 (no output reg) or 2 (output reg).
- `ERR_CNT_WIDTH`, default 3: width of the saturating error counter.

Ports:
- `wr_clk`  in  1  single clock for the engine and both RAM ports.
- `tb_wr_rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request, sampled only in IDLE.
- `mode`  in  2  sampled with `start`: 0 = descending pattern, 1 = address pattern, 2 = read-only checksum, 3 = treated as 2.
- `busy`  out  1  high from the cycle after accepted `start` until DONE.
- `done`  out  1  one-cycle pulse at completion.
- `pass`  out  1  registered at DONE; held until next accepted `start`.
- `ram_wr_en`  out  1  RAM write enable.
- `ram_wr_addr`  out  ADDR_WIDTH  RAM write address.
- `ram_wr_data`  out  DATA_WIDTH  RAM write data.
- `ram_rd_addr`  out  ADDR_WIDTH  RAM read address.
- `ram_rd_data`  in  DATA_WIDTH  RAM read data.
- `err_cnt`  out  ERR_CNT_WIDTH  number of mismatches, saturating.
- `first_err_addr`  out  ADDR_WIDTH  address of the first mismatch.
- `checksum`  out  DATA_WIDTH+ADDR_WIDTH  modular sum of all read data.

## Operation
FSM states: IDLE, WRITE, GAP, READ, DRAIN, DONE.

Transitions:
- IDLE -> WRITE on `start` with mode 0/1.
- IDLE -> READ on `start` with mode 2/3.
- WRITE -> GAP after address N-1 is written.
- GAP -> READ after 1 cycle.
- READ -> DRAIN after address N-1 is issued.
- DRAIN -> DONE after RD_LATENCY cycles.
- DONE -> IDLE after 1 cycle.

Write patterns (truncate to DATA_WIDTH):
- Mode 0: data(a) = all-ones − a.
- Mode 1: data(a) = a, zero-extended.

Reads and checking:
- READ issues `ram_rd_addr` 0..N-1, one address per cycle.
- A valid/expected/address pipeline of depth RD_LATENCY aligns the expected value with `ram_rd_data`.
- Compare happens only in modes 0/1, only on valid pipeline slots.
- On mismatch:
  - `err_cnt` increments, saturating at 2^ERR_CNT_WIDTH−1.
  - `first_err_addr` loads only when `err_cnt` == 0 before the increment.
- `checksum` accumulates every valid read in all modes, wrapping modulo 2^(DATA_WIDTH+ADDR_WIDTH).

Start and results:
- Accepted `start` clears `err_cnt`, `first_err_addr`, `checksum` and `pass`.
- `start` while `busy` or in DONE is ignored.
- `pass` = (`err_cnt` == 0) in modes 0/1, loaded on entering DONE; always 1 in modes 2/3.

## Timing
- Reset values: all outputs 0; FSM IDLE. Assertion of `tb_wr_rst` is immediate and asynchronous, so `ram_wr_en` drops without waiting for a clock edge. Reset mid-operation abandons the run; no `done` is produced.
- `start` sampled at edge k: `busy` = 1 and the first WRITE/READ cycle follow edge k.
- `ram_wr_en` is high for exactly N consecutive cycles, addresses 0..N-1 in order.
- GAP: `ram_wr_en` = 0, no read issued, so no read-during-write on any address.
- Data for the read issued at cycle r is compared at edge r+RD_LATENCY.
- Busy length:
  - modes 0/1: 2N + 1 + RD_LATENCY cycles;
  - modes 2/3: N + RD_LATENCY cycles.
- DONE cycle: `done` = 1, `busy` = 0, `pass`/`err_cnt`/`checksum` final and stable. The next accepted `start` is possible the cycle after DONE.
- `ram_rd_addr` holds its last value outside READ; `ram_wr_addr` and `ram_wr_data` hold their last values outside WRITE.

## Test plan
- ADDR_WIDTH=4, DATA_WIDTH=14, RD_LATENCY=1, behavioural RAM, mode 0 -> `done` 34 cycles after `start` edge; `err_cnt` 0; `pass` 1; `ram_wr_data` at addr 0 = 0x3FFF, at addr 15 = 0x3FF0.
- Same setup, RAM model flips bit 0 on reads of addr 5 -> `err_cnt` 1, `first_err_addr` 5, `pass` 0.
- RAM read data stuck at 0, mode 1, ERR_CNT_WIDTH=3 -> `err_cnt` saturates at 7, `first_err_addr` 1 (addr 0 matches), `pass` 0.
- RAM preloaded with data = a, mode 2, RD_LATENCY=2 -> no write enables; `checksum` 120; `pass` 1; `done` 18 cycles after `start`.
- Assert `tb_wr_rst` at write address 7 -> `ram_wr_en` 0 immediately, all outputs 0, no `done`; a following mode 0 run passes.
- `start` pulsed mid-READ and in the DONE cycle -> ignored: one `done` only, results unchanged, `busy` length as specified.

Source files
------------

// File: rtl/lbg_codebook_bist.sv
// Built-in self test engine for one VQ/LBG codebook SDPRAM.
// Fills the RAM with a pattern, reads it back and compares, or checksums it.
module lbg_codebook_bist #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 14,
  parameter int RD_LATENCY    = 1,
  parameter int ERR_CNT_WIDTH = 3
) (
  input  logic                             wr_clk,
  input  logic                             tb_wr_rst,
  input  logic                             start,
  input  logic [1:0]                       mode,
  output logic                             busy,
  output logic                             done,
  output logic                             pass,
  output logic                             ram_wr_en,
  output logic [ADDR_WIDTH-1:0]            ram_wr_addr,
  output logic [DATA_WIDTH-1:0]            ram_wr_data,
  output logic [ADDR_WIDTH-1:0]            ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]            ram_rd_data,
  output logic [ERR_CNT_WIDTH-1:0]         err_cnt,
  output logic [ADDR_WIDTH-1:0]            first_err_addr,
  output logic [DATA_WIDTH+ADDR_WIDTH-1:0] checksum
);

  localparam int CW = DATA_WIDTH + ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE, WRITE, GAP, READ, DRAIN, DONE
  } state_e;

  state_e state_q, state_d;

  logic [1:0]               mode_q;
  logic [ADDR_WIDTH-1:0]    wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0]    rd_addr_q, rd_addr_d;
  logic [1:0]               dcnt_q, dcnt_d;
  logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
  logic [ADDR_WIDTH-1:0]    first_q, first_d;
  logic [CW-1:0]            csum_q, csum_d;
  logic                     pass_q, pass_d;

  logic [RD_LATENCY-1:0]                 vld_q, vld_d;
  logic [RD_LATENCY-1:0][ADDR_WIDTH-1:0] pa_q, pa_d;

  logic                  wr_last, rd_last, lat_end;
  logic                  rd_ok, mism;
  logic [ADDR_WIDTH-1:0] rd_pa;
  logic [DATA_WIDTH-1:0] exp_w;

  // desc=1: all-ones minus address, desc=0: address itself
  function automatic logic [DATA_WIDTH-1:0] pattern(
    input logic                  desc,
    input logic [ADDR_WIDTH-1:0] a
  );
    if (desc) return {DATA_WIDTH{1'b1}} - DATA_WIDTH'(a);
    return DATA_WIDTH'(a);
  endfunction

  assign wr_last = (wr_addr_q == {ADDR_WIDTH{1'b1}});
  assign rd_last = (rd_addr_q == {ADDR_WIDTH{1'b1}});
  assign lat_end = (dcnt_q == 2'(RD_LATENCY - 1));

  // Alignment pipeline: slot RD_LATENCY-1 matches ram_rd_data
  generate
    if (RD_LATENCY > 1) begin : g_pipe
      assign vld_d = {vld_q[RD_LATENCY-2:0], state_q == READ};
      assign pa_d  = {pa_q[RD_LATENCY-2:0], rd_addr_q};
    end else begin : g_pipe1
      assign vld_d = state_q == READ;
      assign pa_d  = rd_addr_q;
    end
  endgenerate

  assign rd_ok = vld_q[RD_LATENCY-1];
  assign rd_pa = pa_q[RD_LATENCY-1];
  assign exp_w = pattern(~mode_q[0], rd_pa);
  assign mism  = rd_ok && !mode_q[1] && (ram_rd_data != exp_w);

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_addr_d = rd_addr_q;
    dcnt_d    = dcnt_q;
    err_d     = err_q;
    first_d   = first_q;
    csum_d    = csum_q;
    pass_d    = pass_q;

    if (rd_ok) begin
      csum_d = csum_q + CW'(ram_rd_data);
    end
    if (mism) begin
      if (err_q != {ERR_CNT_WIDTH{1'b1}}) begin
        err_d = err_q + ERR_CNT_WIDTH'(1);
      end
      if (err_q == '0) begin
        first_d = rd_pa;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          err_d   = '0;
          first_d = '0;
          csum_d  = '0;
          pass_d  = 1'b0;
          if (mode[1]) begin
            state_d   = READ;
            rd_addr_d = '0;
          end else begin
            state_d   = WRITE;
            wr_addr_d = '0;
            wr_data_d = pattern(~mode[0], '0);
          end
        end
      end
      WRITE: begin
        if (wr_last) begin
          state_d = GAP;
        end else begin
          wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
          wr_data_d = pattern(~mode_q[0],
                              wr_addr_q + ADDR_WIDTH'(1));
        end
      end
      GAP: begin
        state_d   = READ;
        rd_addr_d = '0;
      end
      READ: begin
        if (rd_last) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end else begin
          rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (lat_end) begin
          state_d = DONE;
          pass_d  = mode_q[1] || (err_d == '0);
        end else begin
          dcnt_d = dcnt_q + 2'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_addr_q <= '0;
      dcnt_q    <= '0;
      err_q     <= '0;
      first_q   <= '0;
      csum_q    <= '0;
      pass_q    <= 1'b0;
      vld_q     <= '0;
      pa_q      <= '0;
    end else begin
      state_q   <= state_d;
      if (state_q == IDLE && start) begin
        mode_q <= mode;
      end
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_addr_q <= rd_addr_d;
      dcnt_q    <= dcnt_d;
      err_q     <= err_d;
      first_q   <= first_d;
      csum_q    <= csum_d;
      pass_q    <= pass_d;
      vld_q     <= vld_d;
      pa_q      <= pa_d;
    end
  end

  assign busy           = (state_q == WRITE) || (state_q == GAP) ||
                          (state_q == READ)  || (state_q == DRAIN);
  assign done           = (state_q == DONE);
  assign pass           = pass_q;
  assign ram_wr_en      = (state_q == WRITE);
  assign ram_wr_addr    = wr_addr_q;
  assign ram_wr_data    = wr_data_q;
  assign ram_rd_addr    = rd_addr_q;
  assign err_cnt        = err_q;
  assign first_err_addr = first_q;
  assign checksum       = csum_q;

endmodule

// File: tb/tb_lbg_codebook_bist.sv
// Scoreboard bench for lbg_codebook_bist: two instances (read latency 1 and 2)
// each beside a behavioural RAM with injectable read faults.
module tb_lbg_codebook_bist;

  localparam int AW = 4;
  localparam int DW = 14;
  localparam int CW = DW + AW;
  localparam int N  = 16;

  typedef struct {
    int mode;
    int err;
    int first;
    int csum;
    bit pass;
    int lat;
    int nwr;
    int done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start_s   [2];
  logic [1:0]    mode_s    [2];
  logic          busy_s    [2];
  logic          done_s    [2];
  logic          pass_s    [2];
  logic          wr_en_s   [2];
  logic [AW-1:0] wr_addr_s [2];
  logic [DW-1:0] wr_data_s [2];
  logic [AW-1:0] rd_addr_s [2];
  logic [DW-1:0] rd_data_s [2];
  logic [2:0]    err_s     [2];
  logic [AW-1:0] first_s   [2];
  logic [CW-1:0] csum_s    [2];

  lbg_codebook_bist #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .RD_LATENCY(1), .ERR_CNT_WIDTH(3)
  ) u_rl1 (
    .wr_clk(clk), .tb_wr_rst(rst),
    .start(start_s[0]), .mode(mode_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
    .ram_wr_en(wr_en_s[0]), .ram_wr_addr(wr_addr_s[0]),
    .ram_wr_data(wr_data_s[0]), .ram_rd_addr(rd_addr_s[0]),
    .ram_rd_data(rd_data_s[0]), .err_cnt(err_s[0]),
    .first_err_addr(first_s[0]), .checksum(csum_s[0])
  );

  lbg_codebook_bist #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .RD_LATENCY(2), .ERR_CNT_WIDTH(3)
  ) u_rl2 (
    .wr_clk(clk), .tb_wr_rst(rst),
    .start(start_s[1]), .mode(mode_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
    .ram_wr_en(wr_en_s[1]), .ram_wr_addr(wr_addr_s[1]),
    .ram_wr_data(wr_data_s[1]), .ram_rd_addr(rd_addr_s[1]),
    .ram_rd_data(rd_data_s[1]), .err_cnt(err_s[1]),
    .first_err_addr(first_s[1]), .checksum(csum_s[1])
  );

  // Behavioural RAMs with read-side fault injection
  logic [DW-1:0] mem  [2][N];
  logic [DW-1:0] rdp1 [2];
  logic [DW-1:0] rdp2 [2];
  int flip_a [2];
  bit stuck  [2];

  function automatic logic [DW-1:0] rd_view(int d, logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = mem[d][a];
    if (stuck[d]) return '0;
    if (int'(a) == flip_a[d]) v[0] = ~v[0];
    return v;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (wr_en_s[d]) mem[d][wr_addr_s[d]] <= wr_data_s[d];
      rdp1[d] <= rd_view(d, rd_addr_s[d]);
      rdp2[d] <= rdp1[d];
    end
  end
  assign rd_data_s[0] = rdp1[0];
  assign rd_data_s[1] = rdp2[1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string nm, longint act, longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic bad(string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected", nm);
  endtask

  // Reference model: RAM contents as plain integers, results by counting
  int   ref_mem [2][N];
  int   wr_log  [N];
  exp_t sbq     [2][$];
  exp_t last_e  [2];

  function automatic int pat(int m, int a);
    return (m == 0) ? (16383 - a) : a;
  endfunction

  function automatic exp_t model(int d, int m, int rl);
    exp_t e;
    int cnt, rd;
    cnt     = 0;
    e.mode  = m;
    e.first = 0;
    e.csum  = 0;
    if (m < 2) for (int a = 0; a < N; a++) ref_mem[d][a] = pat(m, a);
    for (int a = 0; a < N; a++) begin
      rd = stuck[d] ? 0 : (ref_mem[d][a] ^ ((a == flip_a[d]) ? 1 : 0));
      e.csum = (e.csum + rd) % (1 << CW);
      if (m < 2 && rd != ref_mem[d][a]) begin
        if (cnt == 0) e.first = a;
        cnt++;
      end
    end
    e.err  = (cnt > 7) ? 7 : cnt;
    e.pass = (m >= 2) || (cnt == 0);
    e.nwr  = (m < 2) ? N : 0;
    e.lat  = (m < 2) ? (2 * N + 1 + rl) : (N + rl);
    return e;
  endfunction

  function automatic longint outs(int d);
    return 64'({busy_s[d], done_s[d], pass_s[d], wr_en_s[d],
                wr_addr_s[d], wr_data_s[d], rd_addr_s[d],
                err_s[d], first_s[d], csum_s[d]});
  endfunction

  // Monitor: checks writes as they happen and results on each done
  int busy_cnt [2];
  int wr_cnt   [2];

  initial begin
    busy_cnt = '{0, 0};
    wr_cnt   = '{0, 0};
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          busy_cnt[d] = 0;
          wr_cnt[d]   = 0;
        end else begin
          if (busy_s[d]) busy_cnt[d]++;
          if (wr_en_s[d]) begin
            if (sbq[d].size() == 0) begin
              bad("unexpected_write");
            end else begin
              chk("wr_addr", wr_addr_s[d], wr_cnt[d]);
              chk("wr_data", wr_data_s[d], pat(sbq[d][0].mode, wr_cnt[d]));
              if (d == 0) wr_log[wr_cnt[d] % N] = int'(wr_data_s[d]);
              wr_cnt[d]++;
            end
          end
          if (done_s[d]) begin
            if (sbq[d].size() == 0) begin
              bad("unexpected_done");
            end else begin
              exp_t e;
              e = sbq[d].pop_front();
              chk("done_busy_low", busy_s[d], 0);
              chk("done_cycle", cyc, e.done_cyc);
              chk("busy_len", busy_cnt[d], e.lat);
              chk("wr_count", wr_cnt[d], e.nwr);
              chk("err_cnt", err_s[d], e.err);
              chk("first_err_addr", first_s[d], e.first);
              chk("checksum", csum_s[d], e.csum);
              chk("pass", pass_s[d], e.pass);
              last_e[d] = e;
            end
            busy_cnt[d] = 0;
            wr_cnt[d]   = 0;
          end
        end
      end
    end
  end

  task automatic launch(int d, int m, int f, bit s);
    exp_t e;
    @(negedge clk);
    flip_a[d] = f;
    stuck[d]  = s;
    e = model(d, m, (d == 0) ? 1 : 2);
    e.done_cyc = cyc + 1 + e.lat;
    sbq[d].push_back(e);
    start_s[d] = 1'b1;
    mode_s[d]  = 2'(m);
    @(negedge clk);
    start_s[d] = 1'b0;
  endtask

  task automatic wait_done(int d);
    for (int i = 0; i < 200 && sbq[d].size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sbq[d].size() != 0) begin
      bad("done_timeout");
      sbq[d].delete();
    end
  endtask

  task automatic pulse_start(int d, int m);
    start_s[d] = 1'b1;
    mode_s[d]  = 2'(m);
    @(negedge clk);
    start_s[d] = 1'b0;
  endtask

  initial begin
    int d, m, f, j;
    bit s, seen;
    rst        = 1'b1;
    start_s    = '{1'b0, 1'b0};
    mode_s     = '{2'd0, 2'd0};
    flip_a     = '{-1, -1};
    stuck      = '{1'b0, 1'b0};
    repeat (3) @(negedge clk);
    chk("reset_outs_rl1", outs(0), 0);
    chk("reset_outs_rl2", outs(1), 0);
    rst = 1'b0;

    // Clean descending-pattern run
    launch(0, 0, -1, 1'b0);
    wait_done(0);
    chk("wdata_addr0", wr_log[0], 'h3FFF);
    chk("wdata_addr15", wr_log[15], 'h3FF0);
    chk("clean_pass", pass_s[0], 1);
    chk("clean_err", err_s[0], 0);

    // Single bit flip on reads of address 5
    launch(0, 0, 5, 1'b0);
    wait_done(0);
    chk("flip_err", err_s[0], 1);
    chk("flip_first", first_s[0], 5);
    chk("flip_pass", pass_s[0], 0);

    // Read data stuck at zero, address pattern
    launch(0, 1, -1, 1'b1);
    wait_done(0);
    chk("stuck_err_sat", err_s[0], 7);
    chk("stuck_first", first_s[0], 1);
    chk("stuck_pass", pass_s[0], 0);

    // Reset in the middle of the write phase
    launch(0, 0, -1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (wr_en_s[0] && wr_addr_s[0] == 4'd7) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) bad("reach_waddr7");
    rst = 1'b1;
    #1;
    chk("rst_wr_en_async", wr_en_s[0], 0);
    chk("rst_outs_async", outs(0), 0);
    sbq[0].delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("rst_stays_idle", outs(0), 0);

    launch(0, 0, -1, 1'b0);
    wait_done(0);
    chk("after_rst_pass", pass_s[0], 1);

    // Latency-2 instance: write address pattern, then checksum only
    launch(1, 1, -1, 1'b0);
    wait_done(1);
    launch(1, 2, -1, 1'b0);
    wait_done(1);
    chk("ro_checksum", csum_s[1], 120);
    chk("ro_pass", pass_s[1], 1);

    // start pulses mid-READ and in the DONE cycle are ignored
    launch(0, 0, -1, 1'b0);
    repeat (24) @(negedge clk);
    pulse_start(0, 1);
    for (int i = 0; i < 60 && !done_s[0]; i++) @(negedge clk);
    if (!done_s[0]) bad("ign_done_seen");
    pulse_start(0, 0);
    repeat (3) begin
      chk("ign_busy_low", busy_s[0], 0);
      @(negedge clk);
    end
    wait_done(0);
    chk("ign_err_kept", err_s[0], last_e[0].err);
    chk("ign_csum_kept", csum_s[0], last_e[0].csum);
    chk("ign_pass_kept", pass_s[0], last_e[0].pass);

    // Randomised runs with random faults and ignored start pulses
    for (int it = 0; it < 14; it++) begin
      d = int'($urandom_range(0, 1));
      m = int'($urandom_range(0, 3));
      f = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      s = ($urandom_range(0, 7) == 0);
      launch(d, m, f, s);
      if ($urandom_range(0, 1) == 1) begin
        j = int'($urandom_range(1, 15));
        repeat (j) @(negedge clk);
        pulse_start(d, int'($urandom_range(0, 3)));
      end
      wait_done(d);
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
